// File: rtl/ppu_pkg.sv
// Shared types and constants for the PPU update sequencer: command layout,
// opcodes, square-state codes and the ship-length lookup.
package ppu_pkg;

  localparam int BOARD_DIM   = 10;
  localparam int NUM_SQUARES = BOARD_DIM * BOARD_DIM;
  localparam logic [6:0] MAX_SQ   = 7'd99;
  localparam logic [6:0] ROW_STEP = 7'd10;

  // cmd_data bit positions
  localparam int CMD_OP_HI    = 15;
  localparam int CMD_OP_LO    = 14;
  localparam int CMD_BOARD    = 13;
  localparam int CMD_SQ_HI    = 12;
  localparam int CMD_SQ_LO    = 6;
  localparam int CMD_STATE_HI = 5;
  localparam int CMD_STATE_LO = 4;
  localparam int CMD_TYPE_HI  = 3;
  localparam int CMD_TYPE_LO  = 2;
  localparam int CMD_VERT     = 1;
  localparam int CMD_SEL      = 0;

  typedef enum logic [1:0] {
    OP_SQUARE = 2'b00,
    OP_SHIP   = 2'b01,
    OP_CLEAR  = 2'b10,
    OP_RSVD   = 2'b11
  } op_e;

  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_MISS  = 2'b01;
  localparam logic [1:0] ST_HIT   = 2'b10;
  localparam logic [1:0] ST_SHIP  = 2'b11;

  // Field order mirrors the bit positions above (MSB first).
  typedef struct packed {
    op_e        op;
    logic       board;
    logic [6:0] square;
    logic [1:0] state;
    logic [1:0] ship_type;
    logic       vert;
    logic       sel;
  } cmd_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SINGLE,
    S_SHIP,
    S_CLEAR
  } seq_state_e;

  // Ship type code 0..3 maps to length 2..5.
  function automatic logic [2:0] ship_len(input logic [1:0] t);
    return {1'b0, t} + 3'd2;
  endfunction

endpackage

// File: rtl/ppu_cmd_fifo.sv
// Small synchronous command FIFO; pointers carry a wrap bit so full and
// empty are distinguished without a separate counter.
module ppu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic         sys_clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wp_q, rp_q;
  logic         do_push, do_pop;

  assign full_o  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign empty_o = (wp_q == rp_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rp_q[AW-1:0]];

  // Pointer update; a push when full is dropped here.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + 1'b1;
      if (do_pop)  rp_q <= rp_q + 1'b1;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge sys_clk) begin
    if (do_push) mem_q[wp_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/ppu_update_sequencer.sv
// Expands queued display commands into single-square update strobes for the
// PPU square table: one square, a whole ship, or a full-board clear.
module ppu_update_sequencer
  import ppu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_data,
  output logic        receive,
  output logic        board,
  output logic [6:0]  square_update,
  output logic [1:0]  square_state,
  output logic [1:0]  ship_type,
  output logic [2:0]  ship_section,
  output logic        vert,
  output logic        square_sel,
  output logic        busy,
  output logic        err
);

  logic [15:0] fifo_rdata;
  logic        fifo_full, fifo_empty, pop;
  cmd_t        head;

  seq_state_e  state_q;
  logic        rcv_q, board_q, vert_q, sel_q, err_q;
  logic [6:0]  sq_q, step_q;
  logic [1:0]  st_q, ty_q;
  logic [2:0]  sec_q, last_q;

  logic [6:0]  rem;
  logic [3:0]  row, col;
  logic [2:0]  len;
  logic [4:0]  h_end, v_end;
  logic        fits, reject;

  ppu_cmd_fifo #(.DEPTH(FIFO_DEPTH), .W(16)) u_fifo (
    .sys_clk (sys_clk),
    .rst     (rst),
    .push_i  (cmd_valid),
    .wdata_i (cmd_data),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign head      = cmd_t'(fifo_rdata);
  assign pop       = (state_q == S_IDLE) && !fifo_empty;
  assign cmd_ready = !fifo_full;
  assign busy      = (state_q != S_IDLE) || !fifo_empty;

  // Decode the FIFO head: row/col by repeated subtract-ten, then range checks.
  always_comb begin
    rem = head.square;
    row = '0;
    for (int k = 0; k < 12; k++) begin
      if (rem >= ROW_STEP) begin
        rem = rem - ROW_STEP;
        row = row + 4'd1;
      end
    end
    col   = rem[3:0];
    len   = ship_len(head.ship_type);
    h_end = {1'b0, col} + {2'b00, len} - 5'd1;
    v_end = {1'b0, row} + {2'b00, len} - 5'd1;
    fits  = head.vert ? (v_end <= 5'd9) : (h_end <= 5'd9);
    unique case (head.op)
      OP_SQUARE: reject = (head.square > MAX_SQ);
      OP_SHIP:   reject = (head.square > MAX_SQ) || !fits;
      OP_CLEAR:  reject = 1'b0;
      default:   reject = 1'b1;
    endcase
  end

  // Sequencer FSM; every PPU-facing output is a register written here.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rcv_q   <= 1'b0;
      board_q <= 1'b0;
      sq_q    <= '0;
      st_q    <= ST_EMPTY;
      ty_q    <= '0;
      sec_q   <= '0;
      vert_q  <= 1'b0;
      sel_q   <= 1'b0;
      err_q   <= 1'b0;
      step_q  <= '0;
      last_q  <= '0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (!fifo_empty) begin
            if (reject) begin
              err_q <= 1'b1;
            end else begin
              rcv_q   <= 1'b1;
              board_q <= head.board;
              sec_q   <= '0;
              unique case (head.op)
                OP_SQUARE: begin
                  sq_q    <= head.square;
                  st_q    <= head.state;
                  ty_q    <= head.ship_type;
                  vert_q  <= head.vert;
                  sel_q   <= head.sel;
                  state_q <= S_SINGLE;
                end
                OP_SHIP: begin
                  sq_q    <= head.square;
                  st_q    <= ST_SHIP;
                  ty_q    <= head.ship_type;
                  vert_q  <= head.vert;
                  sel_q   <= 1'b0;
                  step_q  <= head.vert ? ROW_STEP : 7'd1;
                  last_q  <= len - 3'd1;
                  state_q <= S_SHIP;
                end
                default: begin
                  sq_q    <= '0;
                  st_q    <= ST_EMPTY;
                  ty_q    <= '0;
                  vert_q  <= 1'b0;
                  sel_q   <= 1'b0;
                  state_q <= S_CLEAR;
                end
              endcase
            end
          end
        end
        S_SINGLE: begin
          rcv_q   <= 1'b0;
          state_q <= S_IDLE;
        end
        S_SHIP: begin
          if (sec_q == last_q) begin
            rcv_q   <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            sq_q  <= sq_q + step_q;
            sec_q <= sec_q + 3'd1;
          end
        end
        S_CLEAR: begin
          if (sq_q == MAX_SQ) begin
            rcv_q   <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            sq_q <= sq_q + 7'd1;
          end
        end
      endcase
    end
  end

  assign receive       = rcv_q;
  assign board         = board_q;
  assign square_update = sq_q;
  assign square_state  = st_q;
  assign ship_type     = ty_q;
  assign ship_section  = sec_q;
  assign vert          = vert_q;
  assign square_sel    = sel_q;
  assign err           = err_q;

endmodule

// File: tb/tb_ppu_update_sequencer.sv
// Bench for ppu_update_sequencer: directed scenarios plus random commands,
// compared event-by-event against a list-based model of the command rules.
module tb_ppu_update_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [15:0] cmd_data = '0;
  logic        cmd_ready, receive, board, vert, square_sel, busy, err;
  logic [6:0]  square_update;
  logic [1:0]  square_state, ship_type;
  logic [2:0]  ship_section;

  ppu_update_sequencer dut (
    .sys_clk       (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_data      (cmd_data),
    .receive       (receive),
    .board         (board),
    .square_update (square_update),
    .square_state  (square_state),
    .ship_type     (ship_type),
    .ship_section  (ship_section),
    .vert          (vert),
    .square_sel    (square_sel),
    .busy          (busy),
    .err           (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic       e;
    logic       b;
    logic [6:0] sq;
    logic [1:0] st;
    logic [1:0] ty;
    logic [2:0] sec;
    logic       v;
    logic       s;
  } ev_t;

  ev_t obs[$];
  ev_t expq[$];
  int  obs_cyc[$];
  int  total = 0;
  int  bad   = 0;

  // Log every strobe and every error pulse seen on the outputs.
  always @(negedge clk) begin
    if (receive === 1'b1) begin
      obs.push_back('{e:1'b0, b:board, sq:square_update, st:square_state,
                      ty:ship_type, sec:ship_section, v:vert, s:square_sel});
      obs_cyc.push_back(cyc);
    end
    if (err === 1'b1) begin
      obs.push_back('{e:1'b1, default:'0});
      obs_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  function automatic logic [15:0] mk(input int op, input int b, input int sq,
                                     input int st, input int ty, input int v, input int s);
    logic [15:0] c;
    c = {op[1:0], b[0], sq[6:0], st[1:0], ty[1:0], v[0], s[0]};
    return c;
  endfunction

  // Reference: what the PPU should see for one accepted command.
  function automatic void model(input logic [15:0] c);
    int op, b, sq, st, ty, v, s, row, col, len;
    ev_t x;
    op = int'(c[15:14]); b = int'(c[13]); sq = int'(c[12:6]);
    st = int'(c[5:4]);   ty = int'(c[3:2]); v = int'(c[1]); s = int'(c[0]);
    row = sq / 10; col = sq % 10; len = ty + 2;
    if (op == 3 || (op != 2 && sq > 99) ||
        (op == 1 && (v ? (row + len - 1 > 9) : (col + len - 1 > 9)))) begin
      x = '{e:1'b1, default:'0};
      expq.push_back(x);
    end else if (op == 0) begin
      x = '{e:1'b0, b:b[0], sq:sq[6:0], st:st[1:0], ty:ty[1:0], sec:3'd0, v:v[0], s:s[0]};
      expq.push_back(x);
    end else if (op == 1) begin
      for (int i = 0; i < len; i++) begin
        int p;
        p = v ? sq + 10 * i : sq + i;
        x = '{e:1'b0, b:b[0], sq:p[6:0], st:2'b11, ty:ty[1:0], sec:i[2:0], v:v[0], s:1'b0};
        expq.push_back(x);
      end
    end else begin
      for (int i = 0; i < 100; i++) begin
        x = '{e:1'b0, b:b[0], sq:i[6:0], default:'0};
        expq.push_back(x);
      end
    end
  endfunction

  // Offer one command for a cycle; accepted commands go to the model.
  task automatic push(input logic [15:0] d, output logic acc);
    cmd_valid = 1'b1;
    cmd_data  = d;
    acc       = cmd_ready;
    @(negedge clk);
    cmd_valid = 1'b0;
    if (acc) model(d);
  endtask

  task automatic drain(input int maxc);
    int n;
    n = 0;
    while (busy && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk("drain_idle", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic compare(input string tag);
    chk({tag, "_count"}, 64'(obs.size()), 64'(expq.size()));
    for (int i = 0; i < obs.size() && i < expq.size(); i++)
      chk(tag, 64'(obs[i]), 64'(expq[i]));
    obs.delete();
    expq.delete();
    obs_cyc.delete();
  endtask

  initial begin
    logic acc;
    logic [15:0] c;
    int c0, n, op, r;
    logic exp_rdy [5];

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_receive", 64'(receive), 64'd0);
    chk("rst_fields", 64'({board, square_update, square_state, ship_type,
                          ship_section, vert, square_sel}), 64'd0);
    chk("rst_busy_err", 64'({busy, err}), 64'd0);
    chk("rst_ready", 64'(cmd_ready), 64'd1);
    rst = 1'b0;
    @(negedge clk);

    // Single write with latency check
    c0 = cyc;
    push(16'h2C5E, acc);
    drain(50);
    chk("single_latency", 64'((obs_cyc.size() > 0) ? obs_cyc[0] : -1), 64'(c0 + 2));
    compare("single");
    chk("hold_square", 64'({receive, square_update}), 64'({1'b0, 7'd49}));

    // Horizontal len-5 ship
    push(mk(1, 0, 23, 0, 3, 0, 1), acc);
    drain(50);
    chk("ship_h_contig", 64'((obs_cyc.size() == 5) ? obs_cyc[4] - obs_cyc[0] : -1), 64'd4);
    compare("ship_h");
    chk("hold_ship", 64'({receive, square_update, ship_section}), 64'({1'b0, 7'd27, 3'd4}));

    // Vertical ships: one fits, one overflows
    push(mk(1, 1, 72, 0, 1, 1, 0), acc);
    push(mk(1, 1, 80, 0, 1, 1, 0), acc);
    drain(50);
    compare("ship_v");

    // Assorted rejects, back to back
    push(mk(1, 0, 8, 0, 2, 0, 0), acc);
    push(mk(0, 0, 100, 1, 0, 0, 0), acc);
    push(mk(3, 1, 5, 2, 1, 0, 1), acc);
    drain(50);
    compare("reject");

    // Clear with FIFO filled behind it; fifth push must bounce
    push(mk(2, 1, 0, 3, 3, 1, 1), acc);
    repeat (3) @(negedge clk);
    exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: c = mk(0, 0, 99, 2, 1, 0, 1);
        1: c = mk(1, 1, 60, 0, 0, 1, 0);
        2: c = mk(1, 0, 96, 0, 0, 0, 0);
        3: c = mk(0, 1, 0, 3, 2, 1, 1);
        default: c = mk(0, 1, 11, 1, 1, 1, 1);
      endcase
      push(c, acc);
      chk($sformatf("fill_ready_%0d", i), 64'(acc), 64'(exp_rdy[i]));
    end
    drain(400);
    chk("clear_contig", 64'((obs_cyc.size() > 99) ? obs_cyc[99] - obs_cyc[0] : -1), 64'd99);
    compare("clear_fill");

    // Random commands with random gaps
    for (int k = 0; k < 40; k++) begin
      r  = $urandom_range(0, 9);
      op = (r < 4) ? 0 : (r < 8) ? 1 : (r == 8) ? 2 : 3;
      c  = mk(op, $urandom_range(0, 1), $urandom_range(0, 109), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1));
      push(c, acc);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain(6000);
    compare("random");

    // Reset in the middle of a clear, with a command still queued
    push(mk(2, 0, 0, 0, 0, 0, 0), acc);
    repeat (5) @(negedge clk);
    push(mk(0, 1, 5, 1, 1, 1, 1), acc);
    n = 0;
    while (!(receive === 1'b1 && square_update === 7'd40) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("reach_sq40", 64'(n < 300), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_receive", 64'(receive), 64'd0);
    chk("midrst_busy_ready", 64'({busy, cmd_ready}), 64'({1'b0, 1'b1}));
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("midrst_quiet", 64'({busy, receive}), 64'd0);
    expq.delete();
    model(mk(2, 0, 0, 0, 0, 0, 0));
    while (expq.size() > 41) void'(expq.pop_back());
    compare("midrst");

    // Single write after reset behaves like the first one
    c0 = cyc;
    push(16'h2C5E, acc);
    drain(50);
    chk("post_rst_latency", 64'((obs_cyc.size() > 0) ? obs_cyc[0] : -1), 64'(c0 + 2));
    compare("post_rst_single");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case a wait above is ever bypassed.
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
